// File: rtl/ps2_key_decoder.sv
// PS/2 keyboard receiver: synchronises the PS/2 lines, frames and checks bytes, and turns
// set-2 make/break codes for the 12 card keys into single press events plus a held-key map.
`timescale 1ns / 1ps

module ps2_key_decoder #(
  parameter int unsigned TIMEOUT_CYCLES = 100000,
  parameter int unsigned SYNC_STAGES    = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        ps2_clk,
  input  logic        ps2_dat,
  output logic [7:0]  scan_code,
  output logic        scan_valid,
  output logic        frame_err,
  output logic        key_valid,
  output logic [3:0]  key_index,
  output logic [11:0] key_held
);

  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {StIdle, StData, StParity, StStop} rx_state_e;

  // Synchronisers reset to the idle-high line level so release never looks like an edge.
  logic [SYNC_STAGES-1:0] clk_sync_q, dat_sync_q;
  logic                   clk_prev_q;
  logic                   sync_clk, sync_dat, fall;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      clk_sync_q <= '1;
      dat_sync_q <= '1;
      clk_prev_q <= 1'b1;
    end else begin
      clk_sync_q <= {clk_sync_q[SYNC_STAGES-2:0], ps2_clk};
      dat_sync_q <= {dat_sync_q[SYNC_STAGES-2:0], ps2_dat};
      clk_prev_q <= sync_clk;
    end
  end

  assign sync_clk = clk_sync_q[SYNC_STAGES-1];
  assign sync_dat = dat_sync_q[SYNC_STAGES-1];
  assign fall     = clk_prev_q & ~sync_clk;

  rx_state_e         state_q, state_d;
  logic [2:0]        bitcnt_q, bitcnt_d;
  logic [7:0]        shift_q, shift_d;
  logic              par_q, par_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              rx_good, rx_err;
  logic [7:0]        scan_code_q, scan_code_d;
  logic              scan_valid_q, frame_err_q;

  always_comb begin
    state_d  = state_q;
    bitcnt_d = bitcnt_q;
    shift_d  = shift_q;
    par_d    = par_q;
    cnt_d    = cnt_q + 1'b1;
    rx_good  = 1'b0;
    rx_err   = 1'b0;
    if (state_q == StIdle || fall) begin
      cnt_d = '0;
    end
    if (fall) begin
      unique case (state_q)
        StIdle: begin
          if (!sync_dat) begin
            state_d  = StData;
            bitcnt_d = '0;
          end
        end
        StData: begin
          shift_d  = {sync_dat, shift_q[7:1]};
          bitcnt_d = bitcnt_q + 1'b1;
          if (bitcnt_q == 3'd7) begin
            state_d = StParity;
          end
        end
        StParity: begin
          par_d   = sync_dat;
          state_d = StStop;
        end
        StStop: begin
          // Odd parity over data plus parity bit, and a high stop bit.
          if (sync_dat && (^{shift_q, par_q})) begin
            rx_good = 1'b1;
          end else begin
            rx_err = 1'b1;
          end
          state_d = StIdle;
        end
        default: state_d = StIdle;
      endcase
    end else if (state_q != StIdle && cnt_q == CntW'(TIMEOUT_CYCLES - 1)) begin
      rx_err  = 1'b1;
      state_d = StIdle;
    end
  end

  assign scan_code_d = rx_good ? shift_q : scan_code_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= StIdle;
      bitcnt_q     <= '0;
      shift_q      <= '0;
      par_q        <= 1'b0;
      cnt_q        <= '0;
      scan_code_q  <= '0;
      scan_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      bitcnt_q     <= bitcnt_d;
      shift_q      <= shift_d;
      par_q        <= par_d;
      cnt_q        <= cnt_d;
      scan_code_q  <= scan_code_d;
      scan_valid_q <= rx_good;
      frame_err_q  <= rx_err;
    end
  end

  // Set-2 make codes of the card keys, row by row.
  logic       map_hit;
  logic [3:0] map_idx;

  always_comb begin
    map_hit = 1'b1;
    map_idx = 4'd0;
    unique case (scan_code_q)
      8'h15:   map_idx = 4'd0;
      8'h1D:   map_idx = 4'd1;
      8'h24:   map_idx = 4'd2;
      8'h2D:   map_idx = 4'd3;
      8'h1C:   map_idx = 4'd4;
      8'h1B:   map_idx = 4'd5;
      8'h23:   map_idx = 4'd6;
      8'h2B:   map_idx = 4'd7;
      8'h1A:   map_idx = 4'd8;
      8'h22:   map_idx = 4'd9;
      8'h21:   map_idx = 4'd10;
      8'h2A:   map_idx = 4'd11;
      default: map_hit = 1'b0;
    endcase
  end

  logic        ext_q, ext_d, brk_q, brk_d;
  logic [11:0] held_q, held_d, key_mask;
  logic        key_valid_q, key_valid_d;
  logic [3:0]  key_index_q, key_index_d;

  assign key_mask = 12'd1 << map_idx;

  always_comb begin
    ext_d       = ext_q;
    brk_d       = brk_q;
    held_d      = held_q;
    key_valid_d = 1'b0;
    key_index_d = key_index_q;
    if (frame_err_q) begin
      ext_d = 1'b0;
      brk_d = 1'b0;
    end else if (scan_valid_q) begin
      if (scan_code_q == 8'hE0) begin
        ext_d = 1'b1;
      end else if (scan_code_q == 8'hF0) begin
        brk_d = 1'b1;
      end else begin
        // Extended codes share make bytes with card keys but are different keys.
        if (map_hit && !ext_q) begin
          if (brk_q) begin
            held_d = held_q & ~key_mask;
          end else if ((held_q & key_mask) == 12'd0) begin
            held_d      = held_q | key_mask;
            key_valid_d = 1'b1;
            key_index_d = map_idx;
          end
        end
        ext_d = 1'b0;
        brk_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ext_q       <= 1'b0;
      brk_q       <= 1'b0;
      held_q      <= '0;
      key_valid_q <= 1'b0;
      key_index_q <= '0;
    end else begin
      ext_q       <= ext_d;
      brk_q       <= brk_d;
      held_q      <= held_d;
      key_valid_q <= key_valid_d;
      key_index_q <= key_index_d;
    end
  end

  assign scan_code  = scan_code_q;
  assign scan_valid = scan_valid_q;
  assign frame_err  = frame_err_q;
  assign key_valid  = key_valid_q;
  assign key_index  = key_index_q;
  assign key_held   = held_q;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Bench for ps2_key_decoder: directed scenarios plus random byte streams scored against a
// byte-level keyboard model.
`timescale 1ns / 1ps

module tb_ps2_key_decoder;

  localparam int unsigned T = 300;  // shortened abort timeout
  localparam int          H = 20;   // PS/2 half period in clk cycles

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        ps2_clk = 1'b1;
  logic        ps2_dat = 1'b1;
  logic [7:0]  scan_code;
  logic        scan_valid, frame_err, key_valid;
  logic [3:0]  key_index;
  logic [11:0] key_held;

  ps2_key_decoder #(
    .TIMEOUT_CYCLES(T),
    .SYNC_STAGES   (2)
  ) dut (
    .clk       (clk),
    .resetn    (resetn),
    .ps2_clk   (ps2_clk),
    .ps2_dat   (ps2_dat),
    .scan_code (scan_code),
    .scan_valid(scan_valid),
    .frame_err (frame_err),
    .key_valid (key_valid),
    .key_index (key_index),
    .key_held  (key_held)
  );

  always #10 clk = ~clk;

  int n_checks = 0;
  int n_pass = 0;
  int cyc = 0;
  int last_fall = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Pulse monitor, sampled on the falling clock edge.
  int   sv_cnt = 0, kv_cnt = 0, fe_cnt = 0, long_cnt = 0;
  int   sv_cyc = 0, kv_cyc = 0, fe_cyc = 0;
  logic prev_sv = 1'b0, prev_kv = 1'b0, prev_fe = 1'b0;

  always @(negedge clk) begin
    if (scan_valid) begin sv_cnt++; sv_cyc = cyc; end
    if (key_valid) begin kv_cnt++; kv_cyc = cyc; end
    if (frame_err) begin fe_cnt++; fe_cyc = cyc; end
    if ((scan_valid && prev_sv) || (key_valid && prev_kv) || (frame_err && prev_fe)) long_cnt++;
    prev_sv = scan_valid;
    prev_kv = key_valid;
    prev_fe = frame_err;
  end

  logic [7:0] key_codes [12] = '{8'h15, 8'h1D, 8'h24, 8'h2D, 8'h1C, 8'h1B,
                                 8'h23, 8'h2B, 8'h1A, 8'h22, 8'h21, 8'h2A};

  // Keyboard model: held set, prefix flags, and expected pulse counts per frame.
  logic [11:0] m_held;
  logic        m_ext, m_brk;
  logic [7:0]  m_scan;
  logic [3:0]  m_idx;
  int          e_sv, e_kv, e_fe;

  function automatic int lookup(input logic [7:0] b);
    for (int i = 0; i < 12; i++) if (key_codes[i] == b) return i;
    return -1;
  endfunction

  task automatic model_reset();
    m_held = '0; m_ext = 0; m_brk = 0; m_scan = '0; m_idx = '0;
  endtask

  task automatic model_byte(input logic [7:0] b, input bit good);
    int k;
    if (!good) begin
      e_fe++;
      m_ext = 0;
      m_brk = 0;
    end else begin
      e_sv++;
      m_scan = b;
      if (b == 8'hE0) m_ext = 1;
      else if (b == 8'hF0) m_brk = 1;
      else begin
        k = lookup(b);
        if (k >= 0 && !m_ext) begin
          if (m_brk) m_held[k] = 1'b0;
          else if (!m_held[k]) begin
            m_held[k] = 1'b1;
            e_kv++;
            m_idx = 4'(k);
          end
        end
        m_ext = 0;
        m_brk = 0;
      end
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Frame bits 0..10: start, data LSB first, odd parity, stop.
  task automatic send_bits(input logic [7:0] b, input bit bad, input int lo, input int hi);
    logic [10:0] fr;
    fr = {1'b1, (~(^b)) ^ bad, b, 1'b0};
    for (int i = lo; i <= hi; i++) begin
      ps2_dat = fr[i];
      tick(H);
      ps2_clk = 1'b0;
      last_fall = cyc;
      tick(H);
      ps2_clk = 1'b1;
    end
    ps2_dat = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad);
    send_bits(b, bad, 0, 10);
    tick(10);
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    tick(5);
    n_checks++;
    if ({scan_code, scan_valid, frame_err, key_valid, key_index, key_held} !== 27'd0)
      $display("FAIL reset_outputs: got %h required 0",
               {scan_code, scan_valid, frame_err, key_valid, key_index, key_held});
    else n_pass++;
    resetn = 1'b1;
    tick(5);
  endtask

  task automatic test_first_make();
    int s_sv = sv_cnt, s_kv = kv_cnt;
    send_frame(8'h15, 0);
    n_checks++;
    if (scan_code !== 8'h15) $display("FAIL first_scan_code: got %h required 15", scan_code);
    else n_pass++;
    n_checks++;
    if (sv_cnt - s_sv != 1 || kv_cnt - s_kv != 1)
      $display("FAIL first_pulses: got sv=%0d kv=%0d required 1 1", sv_cnt - s_sv, kv_cnt - s_kv);
    else n_pass++;
    n_checks++;
    if (kv_cyc != sv_cyc + 1)
      $display("FAIL first_kv_latency: got %0d required 1", kv_cyc - sv_cyc);
    else n_pass++;
    n_checks++;
    if (key_index !== 4'd0 || key_held !== 12'h001)
      $display("FAIL first_key: got idx=%0d held=%h required 0 001", key_index, key_held);
    else n_pass++;
  endtask

  task automatic test_typematic();
    int s_sv = sv_cnt, s_kv = kv_cnt;
    repeat (3) send_frame(8'h15, 0);
    n_checks++;
    if (sv_cnt - s_sv != 3 || kv_cnt - s_kv != 0 || key_held !== 12'h001)
      $display("FAIL typematic: got sv=%0d kv=%0d held=%h required 3 0 001",
               sv_cnt - s_sv, kv_cnt - s_kv, key_held);
    else n_pass++;
    send_frame(8'hF0, 0);
    send_frame(8'h15, 0);
    n_checks++;
    if (key_held !== 12'h000 || kv_cnt - s_kv != 0)
      $display("FAIL break: got held=%h kv=%0d required 000 0", key_held, kv_cnt - s_kv);
    else n_pass++;
  endtask

  task automatic test_parity_err();
    int s_sv = sv_cnt, s_kv = kv_cnt, s_fe = fe_cnt;
    send_frame(8'h2A, 1);
    n_checks++;
    if (fe_cnt - s_fe != 1) $display("FAIL parity_frame_err: got %0d required 1", fe_cnt - s_fe);
    else n_pass++;
    n_checks++;
    if (scan_code !== 8'h15 || sv_cnt != s_sv || kv_cnt != s_kv)
      $display("FAIL parity_no_update: got scan=%h sv=%0d kv=%0d required 15 0 0",
               scan_code, sv_cnt - s_sv, kv_cnt - s_kv);
    else n_pass++;
  endtask

  task automatic test_extended();
    int s_sv = sv_cnt, s_kv = kv_cnt;
    send_frame(8'hE0, 0);
    send_frame(8'h1D, 0);
    n_checks++;
    if (sv_cnt - s_sv != 2 || kv_cnt != s_kv || key_held !== 12'h000)
      $display("FAIL extended: got sv=%0d kv=%0d held=%h required 2 0 000",
               sv_cnt - s_sv, kv_cnt - s_kv, key_held);
    else n_pass++;
    send_frame(8'h1D, 0);
    n_checks++;
    if (kv_cnt - s_kv != 1 || key_index !== 4'd1 || key_held !== 12'h002)
      $display("FAIL plain_1d: got kv=%0d idx=%0d held=%h required 1 1 002",
               kv_cnt - s_kv, key_index, key_held);
    else n_pass++;
  endtask

  task automatic test_timeout();
    int s_sv = sv_cnt, s_kv = kv_cnt, s_fe = fe_cnt, edge_cyc;
    send_bits(8'h21, 0, 0, 4);
    edge_cyc = last_fall;
    tick(T + 20);
    n_checks++;
    if (fe_cnt - s_fe != 1 || sv_cnt != s_sv)
      $display("FAIL timeout_err: got fe=%0d sv=%0d required 1 0", fe_cnt - s_fe, sv_cnt - s_sv);
    else n_pass++;
    // Allowance covers the synchroniser and edge-detect pipeline.
    n_checks++;
    if (fe_cyc - edge_cyc < int'(T) || fe_cyc - edge_cyc > int'(T) + 4)
      $display("FAIL timeout_delay: got %0d required %0d..%0d", fe_cyc - edge_cyc, T, T + 4);
    else n_pass++;
    send_frame(8'h21, 0);
    n_checks++;
    if (kv_cnt - s_kv != 1 || key_index !== 4'd10 || key_held !== 12'h402)
      $display("FAIL after_timeout: got kv=%0d idx=%0d held=%h required 1 10 402",
               kv_cnt - s_kv, key_index, key_held);
    else n_pass++;
  endtask

  task automatic test_reset_mid_frame();
    int s_sv, s_kv;
    send_bits(8'h23, 0, 0, 4);
    tick(1);
    resetn = 1'b0;
    tick(3);
    n_checks++;
    if ({scan_code, scan_valid, frame_err, key_valid, key_index, key_held} !== 27'd0)
      $display("FAIL midreset_outputs: got %h required 0",
               {scan_code, scan_valid, frame_err, key_valid, key_index, key_held});
    else n_pass++;
    resetn = 1'b1;
    tick(2);
    s_sv = sv_cnt;
    send_bits(8'h23, 0, 5, 10);
    tick(T + 20);
    n_checks++;
    if (sv_cnt != s_sv) $display("FAIL midreset_tail: got sv=%0d required 0", sv_cnt - s_sv);
    else n_pass++;
    s_kv = kv_cnt;
    send_frame(8'h23, 0);
    n_checks++;
    if (kv_cnt - s_kv != 1 || key_index !== 4'd6 || key_held !== 12'h040)
      $display("FAIL midreset_next: got kv=%0d idx=%0d held=%h required 1 6 040",
               kv_cnt - s_kv, key_index, key_held);
    else n_pass++;
  endtask

  task automatic test_random();
    int s_sv, s_kv, s_fe, r;
    logic [7:0] b;
    bit bad;
    resetn = 1'b0;
    tick(3);
    resetn = 1'b1;
    tick(3);
    model_reset();
    for (int n = 0; n < 40; n++) begin
      r = int'($urandom_range(0, 9));
      if (r < 6) b = key_codes[$urandom_range(0, 11)];
      else if (r == 6) b = 8'hF0;
      else if (r == 7) b = 8'hE0;
      else b = 8'($urandom_range(0, 255));
      bad = ($urandom_range(0, 7) == 0);
      s_sv = sv_cnt; s_kv = kv_cnt; s_fe = fe_cnt;
      e_sv = 0; e_kv = 0; e_fe = 0;
      send_frame(b, bad);
      model_byte(b, !bad);
      n_checks++;
      if (scan_code !== m_scan) $display("FAIL rnd%0d_scan: got %h required %h", n, scan_code, m_scan);
      else n_pass++;
      n_checks++;
      if (sv_cnt - s_sv != e_sv || kv_cnt - s_kv != e_kv || fe_cnt - s_fe != e_fe)
        $display("FAIL rnd%0d_pulses byte=%h: got sv=%0d kv=%0d fe=%0d required %0d %0d %0d",
                 n, b, sv_cnt - s_sv, kv_cnt - s_kv, fe_cnt - s_fe, e_sv, e_kv, e_fe);
      else n_pass++;
      n_checks++;
      if (key_held !== m_held) $display("FAIL rnd%0d_held: got %h required %h", n, key_held, m_held);
      else n_pass++;
      if (e_kv != 0) begin
        n_checks++;
        if (key_index !== m_idx) $display("FAIL rnd%0d_idx: got %0d required %0d", n, key_index, m_idx);
        else n_pass++;
      end
    end
  endtask

  task automatic test_pulse_width();
    n_checks++;
    if (long_cnt != 0) $display("FAIL pulse_width: got %0d long pulses required 0", long_cnt);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_first_make();
    test_typematic();
    test_parity_err();
    test_extended();
    test_timeout();
    test_reset_mid_frame();
    test_random();
    test_pulse_width();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
